// File: rtl/addr_bus_arbiter.sv
// Two-requester round-robin arbiter bridging single-transaction requests onto
// separate write and read buses, with a per-transaction ready timeout.
module addr_bus_arbiter #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 1,
    parameter int TIMEOUT    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              rq_valid,
    input  logic [1:0]              rq_write,
    input  logic [2*ADDR_WIDTH-1:0] rq_addr,
    input  logic [2*DATA_WIDTH-1:0] rq_wdata,
    output logic [1:0]              rq_ready,
    output logic [1:0]              rsp_valid,
    output logic [2*DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]              rsp_err,
    output logic [ADDR_WIDTH-1:0]   write_address,
    output logic [DATA_WIDTH-1:0]   write_data,
    output logic                    write_en,
    input  logic                    write_rdy,
    output logic [ADDR_WIDTH-1:0]   read_address,
    output logic                    read_en,
    input  logic [DATA_WIDTH-1:0]   read_data,
    input  logic                    read_rdy,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_e                  state_q;
    logic                    last_grant_q;
    logic                    idx_q;
    logic                    is_write_q;
    logic [ADDR_WIDTH-1:0]   waddr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [ADDR_WIDTH-1:0]   raddr_q;
    logic [7:0]              cnt_q;
    logic [1:0]              rsp_valid_q;
    logic [1:0]              rsp_err_q;
    logic [2*DATA_WIDTH-1:0] rsp_rdata_q;

    logic                    grant_s;
    logic                    accept_s;
    logic                    issue_s;
    logic [ADDR_WIDTH-1:0]   sel_addr_s;
    logic [DATA_WIDTH-1:0]   sel_wdata_s;
    logic [1:0]              idx_onehot_s;
    logic [2*DATA_WIDTH-1:0] rdata_placed_s;

    // Round-robin choice: on a tie the requester not served last wins.
    always_comb begin
        grant_s = 1'b0;
        if (rq_valid == 2'b11) begin
            grant_s = ~last_grant_q;
        end else if (rq_valid[1]) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Reset gating keeps rq_ready low while reset is held even with valid requests.
    assign accept_s       = (state_q == IDLE) && (|rq_valid) && !reset;
    assign issue_s        = (state_q == ISSUE);
    assign sel_addr_s     = grant_s ? rq_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : rq_addr[ADDR_WIDTH-1:0];
    assign sel_wdata_s    = grant_s ? rq_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : rq_wdata[DATA_WIDTH-1:0];
    assign idx_onehot_s   = idx_q ? 2'b10 : 2'b01;
    assign rdata_placed_s = idx_q ? {read_data, {DATA_WIDTH{1'b0}}} : {{DATA_WIDTH{1'b0}}, read_data};

    // Grant handshake and bus enables follow the ready inputs combinationally.
    always_comb begin
        rq_ready = 2'b00;
        if (accept_s) begin
            rq_ready = grant_s ? 2'b10 : 2'b01;
        end else begin
            rq_ready = 2'b00;
        end
    end

    assign write_en      = issue_s && is_write_q && write_rdy;
    assign read_en       = issue_s && !is_write_q && read_rdy;
    assign write_address = waddr_q;
    assign write_data    = wdata_q;
    assign read_address  = raddr_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_err       = rsp_err_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign busy          = (state_q != IDLE);

    // Transaction FSM: capture on accept, one bus beat or timeout, one response strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            idx_q        <= 1'b0;
            is_write_q   <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            raddr_q      <= '0;
            cnt_q        <= 8'd0;
            rsp_valid_q  <= 2'b00;
            rsp_err_q    <= 2'b00;
            rsp_rdata_q  <= '0;
        end else begin
            rsp_valid_q <= 2'b00;
            rsp_err_q   <= 2'b00;
            rsp_rdata_q <= '0;
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        last_grant_q <= grant_s;
                        idx_q        <= grant_s;
                        is_write_q   <= rq_write[grant_s];
                        cnt_q        <= 8'd0;
                        state_q      <= ISSUE;
                        if (rq_write[grant_s]) begin
                            waddr_q <= sel_addr_s;
                            wdata_q <= sel_wdata_s;
                        end else begin
                            raddr_q <= sel_addr_s;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ISSUE: begin
                    if (write_en || read_en) begin
                        rsp_valid_q <= idx_onehot_s;
                        rsp_rdata_q <= read_en ? rdata_placed_s : '0;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                        // The TIMEOUT-th stalled cycle ends the attempt with an error.
                        if (cnt_q == TO_LAST) begin
                            rsp_valid_q <= idx_onehot_s;
                            rsp_err_q   <= idx_onehot_s;
                            state_q     <= RESP;
                        end else begin
                            state_q <= ISSUE;
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/addr_bus_arbiter.md
ADDR_BUS_ARBITER -- requirements
Module: addr_bus_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, 3, bus address width; DATA_WIDTH, 1, bus data width; TIMEOUT, 8, max cycles waiting for bus ready (legal 1..255).
REQ-002 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  async active-high reset.
REQ-003 SHALL have per-requester ports, index i = 0/1, packed as [1:0] or [2*W-1:0]: rq_valid  in  2  request present; rq_write  in  2  1 = write, 0 = read; rq_addr  in  2*ADDR_WIDTH  target address; rq_wdata  in  2*DATA_WIDTH  write data; rq_ready  out  2  request accepted.
REQ-004 SHALL have per-requester response ports: rsp_valid  out  2  one-cycle response strobe; rsp_rdata  out  2*DATA_WIDTH  read data (0 for writes); rsp_err  out  2  timeout flag.
REQ-005 SHALL have write-bus ports: write_address  out  ADDR_WIDTH; write_data  out  DATA_WIDTH; write_en  out  1; write_rdy  in  1.
REQ-006 SHALL have read-bus ports: read_address  out  ADDR_WIDTH; read_en  out  1; read_data  in  DATA_WIDTH (valid in the read_en cycle); read_rdy  in  1.
REQ-007 SHALL have busy  out  1: high whenever state != IDLE.

Function
REQ-008 SHALL implement FSM states IDLE, ISSUE, RESP; exactly one transaction in flight.
REQ-009 IDLE: if any rq_valid, grant one requester; rq_ready[g] = 1 combinationally for the granted index only; the request is captured (write flag, addr, wdata, index) and the FSM moves to ISSUE next cycle.
REQ-010 Arbitration SHALL be round-robin: if one rq_valid, grant it; if both, grant the index != last_grant; last_grant updates on every accept.
REQ-011 rq_ready SHALL be 0 in ISSUE and RESP; rq_valid in those states is held off, not dropped.
REQ-012 ISSUE (write): write_en = write_rdy, combinational; write_address/write_data driven from the captured request throughout ISSUE; on write_en = 1, go to RESP.
REQ-013 ISSUE (read): read_en = read_rdy, combinational; read_address driven from captured addr; in the read_en cycle, read_data is registered as the response data; go to RESP.
REQ-014 Enables SHALL never be asserted while the matching rdy is low, never both together, and at most one cycle per transaction; write_en/read_en = 0 outside ISSUE.
REQ-015 Timeout: an 8-bit counter clears on entry to ISSUE and increments each ISSUE cycle with the relevant rdy low; when it reaches TIMEOUT, go to RESP with err = 1 and no enable issued.
REQ-016 RESP: rsp_valid[g] = 1 for exactly one cycle, with rsp_rdata[g] (captured read data, 0 for write or timeout) and rsp_err[g]; other index outputs = 0; next state IDLE.
REQ-017 Minimum latency: accept at cycle T, bus transfer at T+1, rsp_valid at T+2; next accept earliest at T+3.
REQ-018 Address/data outputs SHALL hold their last value in IDLE/RESP (no X); after reset they are 0.
REQ-019 rsp_* have no backpressure; requesters SHALL sample them on the strobe.

Reset
REQ-020 On reset assertion, asynchronously: state = IDLE, write_en = read_en = 0, rq_ready = rsp_valid = rsp_err = 0, rsp_rdata = 0, addresses/data = 0, busy = 0, counter = 0, last_grant = 1 (requester 0 wins the first tie).
REQ-021 Reset mid-transaction SHALL abort it with no response strobe; operation resumes on the first clk edge after deassertion.

Verification
REQ-022 Single write: rq0 write addr 4, data 1, write_rdy = 1 -> write_en high one cycle at T+1 with address 4, data 1; rsp_valid[0] at T+2, err 0, rdata 0.
REQ-023 Single read: rq1 read addr 3, read_rdy = 1, read_data = 1 -> read_en one cycle at T+1 with address 3; rsp_valid[1] at T+2, rdata 1.
REQ-024 Tie after reset: both valid continuously with writes -> grants alternate 0, 1, 0, 1; each transaction takes 3 cycles; no enable overlap.
REQ-025 Ready stall: write_rdy low for 3 cycles in ISSUE, then high -> write_en only on the 4th ISSUE cycle; rsp_valid one cycle later with err 0.
REQ-026 Timeout: TIMEOUT = 8, read_rdy stuck low -> no read_en; after 8 ISSUE cycles, rsp_valid with rsp_err = 1 and rdata 0; FSM returns to IDLE.
REQ-027 Reset in ISSUE with rdy low -> all outputs 0 immediately; no rsp_valid; next request is served normally.
